// File: rtl/calc_pkg.sv
// Shared widths, timeout default and the 3-bit state encoding for the
// multiplier operand sequencer.
package calc_pkg;

  localparam int CALC_DW      = 8;
  localparam int CALC_TMO_CYC = 32;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_LOAD  = 3'd1;
  localparam state_t ST_START = 3'd2;
  localparam state_t ST_WAIT  = 3'd3;
  localparam state_t ST_RESP  = 3'd4;

endpackage

// File: rtl/mult_op_sequencer.sv
// Sequences one operand pair through an external multiplier and holds the
// product for a valid/ready consumer. Optional WAIT timeout: MULT_TIMEOUT_EN.
//
// state | meaning
// IDLE  | ready for operands; acceptance latches mul_a/mul_b
// LOAD  | one settle cycle for the multiplier's registered input stage
// START | mul_start pulse
// WAIT  | waiting for mul_done (or timeout)
// RESP  | out_valid held until out_ready
module mult_op_sequencer
  import calc_pkg::*;
#(
  parameter int DW      = CALC_DW,
  parameter int TMO_CYC = CALC_TMO_CYC
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] op_a,
  input  logic [DW-1:0] op_b,
  output logic [DW-1:0] mul_a,
  output logic [DW-1:0] mul_b,
  output logic          mul_start,
  input  logic          mul_done,
  input  logic [DW-1:0] mul_c,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_c,
  output logic          out_clamp,
  output logic          out_err,
  output logic          busy
);

  state_t state;
  logic   tmo_hit;

  // Gating with rst keeps in_ready low while reset is held.
  assign in_ready  = (state == ST_IDLE) && rst;
  assign busy      = (state != ST_IDLE);
  assign mul_start = (state == ST_START);
  assign out_valid = (state == ST_RESP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      mul_a     <= '0;
      mul_b     <= '0;
      out_c     <= '0;
      out_clamp <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            mul_a <= op_a;
            mul_b <= op_b;
            state <= ST_LOAD;
          end
        end
        ST_LOAD:  state <= ST_START;
        ST_START: state <= ST_WAIT;
        ST_WAIT: begin
          if (mul_done) begin
            out_c     <= mul_c;
            out_clamp <= (mul_c == '0) && (mul_a != '0) && (mul_b != '0);
            state     <= ST_RESP;
          end else if (tmo_hit) begin
            out_c     <= '0;
            out_clamp <= 1'b0;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef MULT_TIMEOUT_EN
  localparam int TMO_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

  logic [TMO_W-1:0] tmo_cnt;

  // Loaded on the START->WAIT edge; terminal count on the TMO_CYC-th WAIT cycle.
  assign tmo_hit = (state == ST_WAIT) && (tmo_cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
      out_err <= 1'b0;
    end else begin
      if (state == ST_START) begin
        tmo_cnt <= TMO_W'(TMO_CYC - 1);
      end else if (state == ST_WAIT && tmo_cnt != '0) begin
        tmo_cnt <= tmo_cnt - 1'b1;
      end
      if (state == ST_WAIT) begin
        if (mul_done)     out_err <= 1'b0;
        else if (tmo_hit) out_err <= 1'b1;
      end
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign out_err = 1'b0;
`endif

endmodule

// File: doc/mult_op_sequencer.md
MULT_OP_SEQUENCER -- requirements
Module: mult_op_sequencer

Interface
REQ-001 Parameter: DW, default 8, operand/result width in bits.
REQ-002 Parameter: TMO_CYC, default 32, WAIT-state cycle limit when the timeout feature is compiled in.
REQ-003 clk  input  1  single clock; all flops on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand pair offered.
REQ-006 in_ready  output  1  sequencer accepts operands this cycle.
REQ-007 op_a, op_b  input  DW each  signed two's-complement operands.
REQ-008 mul_a, mul_b  output  DW each  operands driven to the multiplier, held stable from LOAD through WAIT.
REQ-009 mul_start  output  1  one-cycle start pulse to the multiplier.
REQ-010 mul_done  input  1  multiplier completion pulse.
REQ-011 mul_c  input  DW  multiplier result, valid while mul_done=1.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 out_c  output  DW  captured product.
REQ-015 out_clamp  output  1  product is 0 while both operands are nonzero (multiplier range clamp).
REQ-016 out_err  output  1  timeout occurred; 0 unless MULT_TIMEOUT_EN.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 FSM states: IDLE, LOAD, START, WAIT, RESP.
REQ-019 IDLE: in_ready=1; in_valid=1 registers op_a/op_b into mul_a/mul_b and moves to LOAD.
REQ-020 LOAD: exactly one cycle with stable operands, then START (covers the multiplier's registered complement stage).
REQ-021 START: mul_start=1 for exactly one cycle, then WAIT.
REQ-022 WAIT: on mul_done=1, capture mul_c into out_c, compute out_clamp, move to RESP.
REQ-023 out_clamp = (mul_c==0) & (mul_a!=0) & (mul_b!=0), registered with out_c.
REQ-024 RESP: out_valid=1, and out_c/out_clamp/out_err held; out_valid&out_ready returns the FSM to IDLE the next cycle.
REQ-025 in_ready=0 in every state except IDLE; in_valid outside IDLE is ignored and not buffered.
REQ-026 mul_done outside WAIT, including during START, is ignored.
REQ-027 mul_a/mul_b change only on IDLE acceptance.
REQ-028 Minimum latency from acceptance to out_valid: 3 cycles + multiplier latency (LOAD, START, capture).
REQ-029 out_ready=1 in the RESP entry cycle completes the handshake in that cycle; no back-to-back acceptance in the same cycle.

Reset
REQ-030 rst=0 forces IDLE immediately, regardless of clk or current state, including mid-WAIT.
REQ-031 Reset values: in_ready=0 during reset, then 1 in IDLE; all other outputs 0; mul_a/mul_b/out_c = 0.
REQ-032 A mul_done arriving after reset release while in IDLE is ignored.

Configuration
REQ-033 Macro MULT_TIMEOUT_EN defined: a counter runs in WAIT and clears on entry. After TMO_CYC cycles without mul_done, the FSM goes to RESP with out_err=1, out_c=0 and out_clamp=0.
REQ-034 Macro MULT_TIMEOUT_EN undefined: no counter is present, WAIT lasts indefinitely, and out_err is tied 0.

Structure
REQ-035 Shared package calc_pkg holds DW, the FSM state enum encoding (3-bit) and the TMO_CYC default.
REQ-036 No sub-module; the multiplier is instantiated by the parent alongside this block and connected through the mul_* ports.

Verification
REQ-037 op_a=5, op_b=3, model returns mul_c=15 after 13 cycles -> one mul_start pulse, out_valid with out_c=15, out_clamp=0.
REQ-038 op_a=-4 (0xFC), op_b=6, mul_c=0xE8 -> out_c=0xE8; mul_a=0xFC held stable from LOAD until mul_done.
REQ-039 op_a=100, op_b=100, mul_c=0 -> out_c=0, out_clamp=1; op_a=0, op_b=9, mul_c=0 -> out_clamp=0.
REQ-040 out_ready held 0 for 10 cycles in RESP, with in_valid=1 pulses presented -> outputs stable, in_ready=0, no new acceptance; out_ready=1 -> IDLE next cycle.
REQ-041 rst=0 asserted mid-WAIT, then a late mul_done -> immediate IDLE with all outputs 0, and the late mul_done is ignored.
REQ-042 With MULT_TIMEOUT_EN and TMO_CYC=32, mul_done never asserted -> RESP after 32 WAIT cycles with out_err=1 and out_c=0.
